// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the five-stage RISC-V pipeline control blocks.
//   REG_ADDR_W / NUM_REGS : architectural register file geometry.
//   issue_state_e         : issue-controller state (RUN, FLUSH).
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } issue_state_e;

endpackage

// File: rtl/sb_busy_vec.sv
// sb_busy_vec
//   Pending-write bitmap for the issue scoreboard.
//   Optional build macro: SCOREBOARD_WB_BYPASS_EN
//     defined   : busy_view hides the bit being released by this cycle's writeback.
//     undefined : busy_view equals busy_vec.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   set_en, set_idx    mark a register as having an outstanding write
//   clr_en, clr_idx    release a register on writeback
//   busy_vec           registered bitmap, bit 0 always 0
//   busy_view          bitmap as seen by hazard detection this cycle
module sb_busy_vec
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [NUM_REGS-1:0]   busy_view
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // x0 is hardwired, so it is never tracked in either direction.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
        if (clr_en && (clr_idx != '0)) clr_mask[clr_idx] = 1'b1;
    end

    // Set applied after clear: a new writer issued in the same cycle that the
    // previous writer retires keeps the register outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_view = busy_vec & ~clr_mask;
`else
    assign busy_view = busy_vec;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Decode-to-execute issue controller. Tracks in-flight register writes,
//   stalls decode on RAW/WAW hazards and squashes IF/ID after taken branches.
//   Optional build macro: SCOREBOARD_WB_BYPASS_EN (writeback release visible
//   to hazard detection in the writeback cycle itself).
// Parameters
//   FLUSH_CYCLES  cycles squashed after a taken branch, including its own (1..7)
//   CNT_W         width of the stall-cycle counter
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      decode holds a real instruction
//   id_rs1/id_rs2, id_use_rs1/2   sources and their use flags
//   id_rd, id_wr_rd               destination and its write flag
//   wb_en, wb_rd                  writeback commit
//   branch_taken                  one-cycle taken-branch pulse from execute
//   stall, issue, flush_ifid      combinational pipeline-register controls
//   busy_vec                      registered pending-write bitmap
//   stall_cnt                     saturating count of hazard-stall cycles
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal issue; hazards stall decode
// FLUSH | IF/ID squashed while flush_ctr counts down the remaining cycles
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_rd,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  issue,
    output logic                  flush_ifid,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    issue_state_e        state, state_nxt;
    logic [2:0]          flush_ctr, flush_ctr_nxt;
    logic [NUM_REGS-1:0] busy_view;
    logic                hazard;

    sb_busy_vec u_busy (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue & id_wr_rd),
        .set_idx   (id_rd),
        .clr_en    (wb_en),
        .clr_idx   (wb_rd),
        .busy_vec  (busy_vec),
        .busy_view (busy_view)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_ctr <= '0;
        end else begin
            state     <= state_nxt;
            flush_ctr <= flush_ctr_nxt;
        end
    end

    // The branch cycle itself is squashed by branch_taken directly, so the
    // FLUSH state covers the remaining FLUSH_CYCLES-1 cycles. flush_ctr holds
    // the FLUSH cycles still to run including the current one; leaving on the
    // ctr==1 cycle lands it at zero as RUN resumes. With FLUSH_CYCLES==1 no
    // FLUSH cycles are needed at all.
    always_comb begin
        state_nxt     = state;
        flush_ctr_nxt = flush_ctr;
        case (state)
            RUN: begin
                if (branch_taken && (FLUSH_LOAD != 3'd0)) begin
                    state_nxt     = FLUSH;
                    flush_ctr_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    flush_ctr_nxt = FLUSH_LOAD;
                end else begin
                    flush_ctr_nxt = flush_ctr - 3'd1;
                    if (flush_ctr <= 3'd1) state_nxt = RUN;
                end
            end
            default: begin
                state_nxt     = RUN;
                flush_ctr_nxt = '0;
            end
        endcase
    end

    always_comb begin
        hazard     = (id_use_rs1 & busy_view[id_rs1]) |
                     (id_use_rs2 & busy_view[id_rs2]) |
                     (id_wr_rd   & busy_view[id_rd]);
        flush_ifid = branch_taken | (state == FLUSH);
        stall      = id_valid &  hazard & ~flush_ifid;
        issue      = id_valid & ~hazard & ~flush_ifid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           stall_cnt <= '0;
        else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Decode-to-execute issue controller for the five-stage RISC-V pipeline. It sits beside the decode stage and tracks which architectural registers have an in-flight write. It stalls decode on RAW and WAW hazards and releases registers on writeback. When a branch is taken it squashes the IF/ID contents for a fixed number of cycles. Its stall, issue and flush outputs sequence the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles the front end is squashed after a taken branch (1–7).
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  single pipeline clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that source.
- id_rd  in  5  destination register index.
- id_wr_rd  in  1  instruction writes id_rd.
- wb_en  in  1  writeback stage commits a register write this cycle.
- wb_rd  in  5  writeback destination.
- branch_taken  in  1  one-cycle pulse from execute: taken branch or jump.
- stall  out  1  hold PC and IF/ID; combinational.
- issue  out  1  ID/EX captures a valid instruction; combinational.
- flush_ifid  out  1  zero IF/ID (insert bubble); combinational.
- busy_vec  out  32  registered pending-write bitmap; bit 0 always 0.
- stall_cnt  out  CNT_W  registered count of hazard-stall cycles.

## Operation
- States: RUN and FLUSH. The reset state is RUN.
- RUN → FLUSH on branch_taken. This loads flush_ctr with FLUSH_CYCLES-1.
- In FLUSH, flush_ctr decrements each cycle. FLUSH → RUN when flush_ctr==0.
- branch_taken during FLUSH reloads flush_ctr with FLUSH_CYCLES-1.
- Hazard, combinational:
  - (id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]) | (id_wr_rd & busy[id_rd]).
  - Busy bits for index 0 are forced to 0.
- stall = id_valid & hazard & state==RUN & !branch_taken.
- issue = id_valid & !hazard & state==RUN & !branch_taken.
- flush_ifid = branch_taken | state==FLUSH. While flush_ifid is high, stall is 0.
- busy_vec update each edge:
  - Clear bit wb_rd if wb_en.
  - Then set bit id_rd if issue & id_wr_rd & id_rd!=0.
  - Set wins when both target the same index (new writer outstanding).
- Writes to x0 never set or clear anything.
- Flush does not clear busy bits: already-issued instructions still write back.
- wb_en with a non-busy wb_rd is legal and has no effect.
- stall_cnt increments on every cycle with stall=1. It saturates at all-ones.

## Timing
- Reset (asynchronous, immediate): state=RUN, flush_ctr=0, busy_vec=0, stall_cnt=0.
  - stall, issue and flush_ifid then follow their equations with busy_vec=0 and state RUN.
  - Reset mid-flush or with writes pending discards all tracking.
- Issue-to-busy latency: 1 cycle. Writeback-to-release latency: 1 cycle.
  - Without bypass, a dependent instruction issues the cycle after the wb_en cycle.
- A taken branch at cycle T squashes at T through T+FLUSH_CYCLES-1.
  - The first possible issue is at T+FLUSH_CYCLES.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined:
  - A source or destination whose bit is cleared by wb_en/wb_rd in the current cycle is treated as not busy that cycle.
  - The register file must then supply write-data forwarding.
  - Dependent instructions issue in the wb_en cycle itself.
- Not defined: the hazard equation uses busy_vec only. This gives one extra stall cycle.

## Structure
- Shared package riscv_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - The issue-controller state enum {RUN, FLUSH}.
- One sub-module, sb_busy_vec, holds the 32-bit bitmap:
  - set/clear ports with set-priority.
  - x0 masking.
  - An optional bypass-clear view.
- The FSM, counter and hazard logic stay in issue_scoreboard.

## Test plan
- Reset with id_valid=1, rs1=5, use_rs1=1 → issue=1, busy_vec=0.
- Issue rd=3, then next cycle rs1=3 → stall=1 until wb_en/wb_rd=3. Issue occurs at the wb cycle+1 (bypass off) or in the wb cycle (bypass on). stall_cnt equals the stall cycles.
- Same cycle: issue rd=7 while wb_en rd=7 → busy_vec[7]=1 afterwards.
- Instruction with rd=0 and wr_rd=1 → busy_vec stays 0. A following read of x0 never stalls.
- branch_taken at T with FLUSH_CYCLES=2:
  - flush_ifid=1 at T and T+1; issue=0 in both cycles; issue possible at T+2.
  - A second branch_taken at T+1 extends the flush through T+2.
- Assert rst mid-FLUSH with busy_vec=0x0000_0110 → everything clears immediately and issue follows id_valid.
